// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one asynchronous SRAM between a CPU port and a program-loader port
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic [15:0] ld_rdata,
  output logic        ld_done,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [15:0] Mem_ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_oe,
  input  logic [15:0] Data_from_SRAM,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        last_ld;
  logic        sel_ld;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        grant_ld;
  logic        start;
  logic        last_cycle;
  // Loader wins only when it is alone or the CPU was served last.
  assign grant_ld   = ld_req && (!cpu_req || !last_ld);
  assign start      = state == IDLE && (cpu_req || ld_req);
  assign last_cycle = cnt == 4'd1;
  assign Mem_ADDR     = addr_q;
  assign Data_to_SRAM = wdata_q;
  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_next;
  end
  // Grant bookkeeping: latch the winner's request fields and arm the strobe counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= 4'd0;
      last_ld <= 1'b1;
      sel_ld  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
    end else if (start) begin
      cnt     <= 4'(WAIT_CYCLES);
      last_ld <= grant_ld;
      sel_ld  <= grant_ld;
      addr_q  <= grant_ld ? ld_addr : cpu_addr;
      wdata_q <= grant_ld ? ld_wdata : cpu_wdata;
    end else if (state == READ || state == WRITE) begin
      cnt <= cnt - 4'd1;
    end
  end
  // Read data lands in the granted port's register on the final strobe cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_rdata <= 16'h0000;
      ld_rdata  <= 16'h0000;
    end else if (state == READ && last_cycle) begin
      cpu_rdata <= sel_ld ? cpu_rdata : Data_from_SRAM;
      ld_rdata  <= sel_ld ? Data_from_SRAM : ld_rdata;
    end
  end
  // Next state and SRAM strobes; everything idles high unless an access is in flight.
  always_comb begin
    state_next = state;
    Mem_CE     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Mem_UB     = 1'b1;
    Mem_LB     = 1'b1;
    Data_oe    = 1'b0;
    cpu_done   = 1'b0;
    ld_done    = 1'b0;
    busy       = state != IDLE;
    case (state)
      IDLE: state_next = start ? ((grant_ld ? ld_we : cpu_we) ? WRITE : READ) : IDLE;
      READ: begin
        Mem_CE     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_UB     = 1'b0;
        Mem_LB     = 1'b0;
        state_next = last_cycle ? DONE : READ;
      end
      WRITE: begin
        Mem_CE     = 1'b0;
        Mem_WE     = 1'b0;
        Mem_UB     = 1'b0;
        Mem_LB     = 1'b0;
        Data_oe    = 1'b1;
        state_next = last_cycle ? DONE : WRITE;
      end
      DONE: begin
        cpu_done   = !sel_ld;
        ld_done    = sel_ld;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with an SRAM model and a transaction-level reference
module tb_sram_arbiter;
  localparam int W = 2;
  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          start;
  } txn_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0, ld_addr = 16'h0, ld_wdata = 16'h0;
  logic [15:0] cpu_rdata, ld_rdata, Mem_ADDR, Data_to_SRAM;
  logic [15:0] dfs = 16'h0;
  logic        cpu_done, ld_done, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_oe, busy;
  int          vectors = 0;
  int          miscompares = 0;
  txn_t        q[$];
  int          edge_n = 0;
  int          free_at = 0;
  bit          last_ld = 1'b1;
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] sram [logic [15:0]];
  logic [15:0] m_rdata [2];
  logic [15:0] m_addr = 16'h0;
  bit          aux_done = 1'b0;
  logic        aux_rst = 1'b1;
  logic [1:0]  a_req = 2'b00;
  logic [15:0] a_addr [2];
  logic [15:0] a_rdata [2], a_ld_rdata [2], a_maddr [2], a_dts [2], a_dfs [2];
  logic [1:0]  a_done, a_ld_done, a_ce, a_ub, a_lb, a_oe, a_we, a_doe, a_busy;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(clk), .Reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_oe(Data_oe),
    .Data_from_SRAM(dfs), .busy(busy));

  sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(clk), .Reset(aux_rst),
    .cpu_req(a_req[0]), .cpu_we(1'b0), .cpu_addr(a_addr[0]), .cpu_wdata(16'h0),
    .cpu_rdata(a_rdata[0]), .cpu_done(a_done[0]),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0), .ld_wdata(16'h0),
    .ld_rdata(a_ld_rdata[0]), .ld_done(a_ld_done[0]),
    .Mem_CE(a_ce[0]), .Mem_UB(a_ub[0]), .Mem_LB(a_lb[0]), .Mem_OE(a_oe[0]), .Mem_WE(a_we[0]),
    .Mem_ADDR(a_maddr[0]), .Data_to_SRAM(a_dts[0]), .Data_oe(a_doe[0]),
    .Data_from_SRAM(a_dfs[0]), .busy(a_busy[0]));

  sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(clk), .Reset(aux_rst),
    .cpu_req(a_req[1]), .cpu_we(1'b0), .cpu_addr(a_addr[1]), .cpu_wdata(16'h0),
    .cpu_rdata(a_rdata[1]), .cpu_done(a_done[1]),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0), .ld_wdata(16'h0),
    .ld_rdata(a_ld_rdata[1]), .ld_done(a_ld_done[1]),
    .Mem_CE(a_ce[1]), .Mem_UB(a_ub[1]), .Mem_LB(a_lb[1]), .Mem_OE(a_oe[1]), .Mem_WE(a_we[1]),
    .Mem_ADDR(a_maddr[1]), .Data_to_SRAM(a_dts[1]), .Data_oe(a_doe[1]),
    .Data_from_SRAM(a_dfs[1]), .busy(a_busy[1]));

  // Power-up SRAM contents; address 0x0010 holds 0x1234.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a == 16'h0010 ? 16'h1234 : a ^ 16'h5A5A;
  endfunction

  assign a_dfs[0] = init_val(a_maddr[0]);
  assign a_dfs[1] = init_val(a_maddr[1]);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  // SRAM environment: absorbs writes and presents read data mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!Mem_CE && !Mem_WE) sram[Mem_ADDR] = Data_to_SRAM;
    dfs = sram.exists(Mem_ADDR) ? sram[Mem_ADDR] : init_val(Mem_ADDR);
  end

  // Reference model: at each edge decide who is granted and when that access finishes.
  initial begin
    bit  p;
    txn_t t;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        free_at = edge_n + 1;
        last_ld = 1'b1;
      end else if (edge_n >= free_at && (cpu_req || ld_req)) begin
        p = !(cpu_req && (!ld_req || last_ld));
        t.port  = p;
        t.we    = p ? ld_we : cpu_we;
        t.addr  = p ? ld_addr : cpu_addr;
        t.wdata = p ? ld_wdata : cpu_wdata;
        t.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_val(t.addr);
        t.start = edge_n;
        if (t.we) ref_mem[t.addr] = t.wdata;
        q.push_back(t);
        last_ld = p;
        free_at = edge_n + W + 2;
      end
    end
  end

  // Monitor: compares every output against the oldest pending transaction.
  initial begin
    bit   has, act, dn;
    txn_t t;
    m_rdata[0] = 16'h0;
    m_rdata[1] = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        q.delete();
        m_rdata[0] = 16'h0;
        m_rdata[1] = 16'h0;
        m_addr = 16'h0;
      end
      has = q.size() > 0;
      if (has) t = q[0];
      act = has && edge_n < t.start + W;
      dn  = has && edge_n == t.start + W;
      if (has && edge_n == t.start) m_addr = t.addr;
      if (dn && !t.we) m_rdata[t.port] = t.rdata;
      chk("busy", busy, has);
      chk("mem_ce", Mem_CE, !act);
      chk("mem_oe", Mem_OE, !(act && !t.we));
      chk("mem_we", Mem_WE, !(act && t.we));
      chk("mem_ub_lb", {Mem_UB, Mem_LB}, act ? 2'b00 : 2'b11);
      chk("data_oe", Data_oe, act && t.we);
      chk("mem_addr", Mem_ADDR, m_addr);
      if (act && t.we) chk("data_to_sram", Data_to_SRAM, t.wdata);
      chk("cpu_done", cpu_done, dn && !t.port);
      chk("ld_done", ld_done, dn && t.port);
      chk("cpu_rdata", cpu_rdata, m_rdata[0]);
      chk("ld_rdata", ld_rdata, m_rdata[1]);
      if (dn) void'(q.pop_front());
    end
  end

  // One request on a port, held until its done (optionally dropped early with the address scrambled).
  task automatic drive(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d, input int drop);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    if (p) begin ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (i == drop) begin
        if (p) begin ld_req = 1'b0; ld_addr = 16'hFFFF; end
        else begin cpu_req = 1'b0; cpu_addr = 16'hFFFF; end
      end
      seen = p ? ld_done : cpu_done;
    end
    if (!seen) chk(p ? "ld_done_timeout" : "cpu_done_timeout", 16'h0, 16'h1);
  endtask

  // Strobe width and latency for WAIT_CYCLES=1 and 15 with back-to-back reads.
  initial begin
    int w, n, low;
    a_addr[0] = 16'h0;
    a_addr[1] = 16'h0;
    repeat (3) @(negedge clk);
    aux_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w = k ? 15 : 1;
      @(negedge clk);
      a_addr[k] = 16'h0100;
      a_req[k] = 1'b1;
      for (int r = 0; r < 3; r++) begin
        n = 0;
        low = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
          if (!a_oe[k]) low++;
          chk("aux_we_idle", {a_we[k], a_ld_done[k]}, 2'b10);
        end while (!a_done[k] && n < 50);
        chk(k ? "w15_latency" : "w1_latency", 16'(n), 16'(r == 0 ? w + 1 : w + 2));
        chk(k ? "w15_width" : "w1_width", 16'(low), 16'(w));
        chk(k ? "w15_rdata" : "w1_rdata", a_rdata[k], init_val(a_addr[k]));
        a_addr[k] = a_addr[k] + 16'h0011;
      end
      a_req[k] = 1'b0;
    end
    aux_done = 1'b1;
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // CPU read of a preloaded word, then a loader write.
    drive(0, 0, 16'h0010, 16'h0000, 0);
    cpu_req = 1'b0;
    drive(1, 1, 16'h3000, 16'hBEEF, 0);
    ld_req = 1'b0;
    // Request withdrawn and address changed during the first READ cycle.
    drive(0, 0, 16'h0020, 16'h0000, 1);
    cpu_req = 1'b0;
    // Reset during the second WRITE cycle aborts the access.
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 16'h3004; ld_wdata = 16'hCAFE; ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Both ports held through a reset release: CPU first, then strict alternation.
    @(negedge clk);
    rst = 1'b1;
    fork
      begin
        drive(0, 0, 16'h0041, 16'h0000, 0);
        drive(0, 1, 16'h0042, 16'h1111, 0);
        cpu_req = 1'b0;
      end
      begin
        drive(1, 1, 16'h0043, 16'h2222, 0);
        drive(1, 0, 16'h0042, 16'h0000, 0);
        ld_req = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    // Random contention over a small address window.
    fork
      for (int i = 0; i < 40; i++) begin
        drive(0, 1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 7)), 16'($urandom), 0);
        if ($urandom_range(0, 1) == 1) begin
          cpu_req = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      for (int i = 0; i < 40; i++) begin
        drive(1, 1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 7)), 16'($urandom), 0);
        if ($urandom_range(0, 1) == 1) begin
          ld_req = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    join
    cpu_req = 1'b0;
    ld_req = 1'b0;
    for (int i = 0; i < 2000 && !aux_done; i++) @(negedge clk);
    if (!aux_done) chk("aux_timeout", 16'h0, 16'h1);
    repeat (6) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001: Parameter WAIT_CYCLES, default 2, SHALL set the number of cycles the SRAM strobe stays asserted per access; legal range 1..15.
REQ-002: Clk  input  1  system clock; all state changes on rising edge.
REQ-003: Reset  input  1  synchronous, active-high reset.
REQ-004: cpu_req  input  1  CPU (ISDU-driven) access request; level, held until cpu_done.
REQ-005: cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req at grant.
REQ-006: cpu_addr  input  16  CPU word address.
REQ-007: cpu_wdata  input  16  CPU write data.
REQ-008: cpu_rdata  output  16  read data returned to CPU.
REQ-009: cpu_done  output  1  one-cycle pulse, CPU access complete.
REQ-010: ld_req, ld_we, ld_addr[15:0], ld_wdata[15:0], ld_rdata[15:0], ld_done SHALL mirror REQ-004..009 for the program-loader port.
REQ-011: Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  SRAM strobes, active-low.
REQ-012: Mem_ADDR  output  16  SRAM address.
REQ-013: Data_to_SRAM  output  16  write data; Data_oe  output  1  tristate enable for Data_to_SRAM (1 = drive bus).
REQ-014: Data_from_SRAM  input  16  SRAM read bus.
REQ-015: busy  output  1  high in every state except IDLE.

Function
REQ-016: FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-017: In IDLE with any request high, SHALL grant one port, latch its we/addr/wdata, load wait counter with WAIT_CYCLES, go to READ (we=0) or WRITE (we=1).
REQ-018: Arbitration SHALL be round-robin: on simultaneous requests the port not granted last wins; a lone requester always wins.
REQ-019: After reset the last-granted pointer SHALL be the loader, so the CPU wins the first contention.
REQ-020: READ: Mem_CE=0, Mem_OE=0, Mem_UB=Mem_LB=0, Mem_WE=1, Data_oe=0 for exactly WAIT_CYCLES cycles.
REQ-021: Data_from_SRAM SHALL be captured into the granted port's rdata register on the last READ cycle.
REQ-022: WRITE: Mem_CE=0, Mem_WE=0, Mem_UB=Mem_LB=0, Mem_OE=1, Data_oe=1, Data_to_SRAM = latched wdata for exactly WAIT_CYCLES cycles.
REQ-023: Mem_ADDR SHALL equal the latched address throughout READ/WRITE; it holds its last value elsewhere.
REQ-024: After the last READ/WRITE cycle, SHALL enter DONE for one cycle, pulse the granted port's done, return to IDLE.
REQ-025: Grant-to-done latency SHALL be WAIT_CYCLES+1 cycles after the IDLE grant cycle; a held request is re-serviced no earlier than the cycle after DONE.
REQ-026: Request deasserted mid-access SHALL NOT abort it; the access completes and done still pulses.
REQ-027: Port inputs changing after grant SHALL NOT affect the current access (latched values only).
REQ-028: Outside READ/WRITE: Mem_CE=Mem_OE=Mem_WE=Mem_UB=Mem_LB=1, Data_oe=0.
REQ-029: rdata registers SHALL hold value until overwritten by that port's next read; writes leave them unchanged.
REQ-030: Never more than one done high per cycle; Mem_OE and Mem_WE SHALL never both be 0.

Reset
REQ-031: Reset SHALL force IDLE, counter 0, both rdata 0, done 0, busy 0, Mem_ADDR 0, Data_oe 0, all Mem_* strobes 1, pointer per REQ-019.
REQ-032: Reset asserted mid-access SHALL abort immediately (strobes high next edge), no done pulse.
REQ-033: Requests held through Reset release SHALL be evaluated in the first IDLE cycle after release.

Verification
REQ-034: CPU read addr 0x0010, SRAM returns 0x1234, WAIT_CYCLES=2 -> OE low 2 cycles, cpu_done pulses 3 cycles after grant, cpu_rdata=0x1234.
REQ-035: Loader write addr 0x3000 data 0xBEEF -> WE low 2 cycles, Data_oe=1, Data_to_SRAM=0xBEEF, ld_done pulses once, OE stays 1.
REQ-036: Both ports request continuously from reset -> grant order CPU, loader, CPU, loader; dones alternate, never overlap.
REQ-037: cpu_req dropped after 1 READ cycle, cpu_addr changed to 0xFFFF -> Mem_ADDR stays original, cpu_done still pulses.
REQ-038: Reset in second WRITE cycle -> next edge all strobes 1, Data_oe 0, no done pulse, busy 0.
REQ-039: WAIT_CYCLES=1 and WAIT_CYCLES=15 back-to-back reads -> strobe width 1 and 15 cycles respectively, latency per REQ-025.
